// File: rtl/single_port_ram_64x8.sv
// Single-port synchronous RAM with registered, write-through read port.
// A zero-fill sweep runs after every reset; ready rises when it is done.
module single_port_ram_64x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_nxt;
    logic [DATA_WIDTH-1:0]   q_nxt;
    logic                    ready_nxt;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            q     <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
            ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q;
        ready_nxt = ready;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = data;
        unique case (state)
            CLEAR: begin
                // user inputs are ignored until the sweep finishes
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                q_nxt     = '0;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end
            end
            RUN: begin
                if (we) begin
                    mem_we = 1'b1;
                    q_nxt  = data;
                end else begin
                    q_nxt = mem[addr];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_single_port_ram_64x8.sv
// Randomized bench for single_port_ram_64x8 against an array-based model.
// Directed test-plan checks are mixed in alongside the model comparisons.
module tb_single_port_ram_64x8;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic [5:0] addr;
    logic       we;
    logic [7:0] q;
    logic       ready;

    int errs;
    int checks;

    logic [7:0] ref_mem [64];
    int         sweep;
    logic [7:0] ref_q;
    logic       ref_rdy;

    single_port_ram_64x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .addr  (addr),
        .we    (we),
        .q     (q),
        .ready (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sweep   = 0;
        ref_q   = 8'h00;
        ref_rdy = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    endtask

    // one clock: apply inputs, advance, update model, compare
    task automatic cyc(input bit w, input int a, input int d);
        logic [5:0] aa;
        logic [7:0] dd;
        aa   = a[5:0];
        dd   = d[7:0];
        we   = w;
        addr = aa;
        data = dd;
        @(posedge clk);
        #1;
        if (sweep < 64) begin
            sweep++;
            ref_q   = 8'h00;
            ref_rdy = (sweep == 64);
        end else if (w) begin
            ref_mem[aa] = dd;
            ref_q       = dd;
        end else begin
            ref_q = ref_mem[aa];
        end
        chk("q", {24'h0, q}, {24'h0, ref_q});
        chk("ready", {31'h0, ready}, {31'h0, ref_rdy});
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc($urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0) ? 16 : $urandom_range(0, 63),
                $urandom_range(0, 255));
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        addr   = '0;
        data   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", {24'h0, q}, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) cyc(1'b1, 8, 8'h5A);
        chk("sweep_ready", {31'h0, ready}, 32'h1);

        cyc(1'b0, 0, 0);
        chk("zero_a0", {24'h0, q}, 32'h00);
        cyc(1'b0, 17, 0);
        chk("zero_a17", {24'h0, q}, 32'h00);
        cyc(1'b0, 63, 0);
        chk("zero_a63", {24'h0, q}, 32'h00);
        cyc(1'b0, 8, 0);
        chk("clear_ignored_we", {24'h0, q}, 32'h00);

        cyc(1'b1, 5, 8'hA5);
        chk("wt_a5", {24'h0, q}, 32'hA5);
        cyc(1'b0, 5, 0);
        chk("rd_a5", {24'h0, q}, 32'hA5);

        cyc(1'b1, 0, 8'h11);
        cyc(1'b1, 63, 8'h22);
        cyc(1'b1, 31, 8'h33);
        cyc(1'b0, 0, 0);
        chk("rd_a0", {24'h0, q}, 32'h11);
        cyc(1'b0, 63, 0);
        chk("rd_a63", {24'h0, q}, 32'h22);
        cyc(1'b0, 31, 0);
        chk("rd_a31", {24'h0, q}, 32'h33);

        cyc(1'b1, 16, 8'h01);
        chk("b2b_1", {24'h0, q}, 32'h01);
        cyc(1'b1, 16, 8'hFF);
        chk("b2b_2", {24'h0, q}, 32'hFF);
        cyc(1'b0, 16, 0);
        chk("b2b_rd", {24'h0, q}, 32'hFF);

        rand_cycles(400);

        cyc(1'b1, 32, 8'hC3);
        chk("wr_c3", {24'h0, q}, 32'hC3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", {24'h0, q}, 32'h0);
        chk("mid_rst_ready", {31'h0, ready}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_cycles(64);
        chk("resweep_ready", {31'h0, ready}, 32'h1);
        cyc(1'b0, 32, 0);
        chk("lost_a20", {24'h0, q}, 32'h00);

        rand_cycles(300);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/single_port_ram_64x8.md
Name: single_port_ram_64x8

Overview:
- Synchronous single-port RAM, 64 words x 8 bits by default, with one shared address for read and write.
- Provides write-through read behaviour, a registered read output, and an asynchronous active-low reset.
- After reset the block runs an automatic zero-fill sweep, so contents are deterministic before first use.
- Used as a general-purpose scratch/buffer memory inside the datapath.

Parameters:
- DATA_WIDTH, 8, width of each word and of data/q.
- ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH (64).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- data  input  DATA_WIDTH  write data.
- addr  input  ADDR_WIDTH  read/write address.
- we  input  1  write enable, active-high, sampled on rising clk.
- q  output  DATA_WIDTH  registered read data.
- ready  output  1  high once the post-reset clear sweep is complete.

Behaviour:
- Reset (rst_n low, asynchronous):
  - q <= 0, ready <= 0, clear counter <= 0, FSM enters CLEAR.
  - Memory array is not reset directly.
- FSM states CLEAR and RUN:
  - CLEAR: each rising clk writes 0 to mem[counter], then counter increments.
  - When counter = 2**ADDR_WIDTH-1 has been written, the next state is RUN and ready becomes 1 on that same edge.
  - The sweep takes exactly 64 cycles after rst_n deasserts (default depth).
  - In CLEAR, we/data/addr are ignored and q holds 0.
- RUN, rising clk:
  - we=1: mem[addr] <= data and q <= data (write-through, new data).
  - we=0: q <= mem[addr].
  - Read latency is 1 cycle: q reflects the address sampled at the previous edge.
- q holds its value between edges. Address and data are only sampled at rising edges.
- Consecutive writes to the same address: the last write wins, and q shows each written value in turn.
- Write followed by a read of the same address on the next cycle returns the newly written data.
- Address covers the full range 0..63. No out-of-range case exists and there is no wrap logic.
- Reset asserted mid-operation:
  - q and ready clear immediately.
  - The sweep restarts after deassertion, and all prior contents are lost (zeroed).
- Data is stored unsigned and verbatim. No arithmetic on contents.
- The addr input is not modified by the block.
- X on we while ready=1 is a usage error. Behaviour is unspecified, but the array must not be corrupted at addresses other than addr.

Test Plan:
- Reset, then release rst_n -> q=0 and ready=0 for 64 cycles, then ready=1. A read of addr 0, 17 and 63 returns 0x00 each.
- ready=1, we=1, addr=0x05, data=0xA5 -> q=0xA5 after the edge. Then we=0, addr=0x05 -> q=0xA5 on the next edge.
- Write 0x11 to addr 0, 0x22 to addr 63, 0x33 to addr 31, then read each back with we=0 -> q=0x11, 0x22, 0x33 at 1-cycle latency, in order.
- Back-to-back writes 0x01 then 0xFF to addr 0x10, then read -> q=0x01, then 0xFF, then 0xFF.
- With we=1 asserted during CLEAR (ready=0) at addr 0x08, data=0x5A -> ignored. Reading addr 0x08 after ready returns 0x00.
- Write 0xC3 to addr 0x20, assert rst_n low mid-cycle -> q=0 immediately. After the 64-cycle sweep, a read of 0x20 returns 0x00.
